// File: rtl/sha_feeder_pkg.sv
// ---------------------------------------------------------------------------
// sha_feeder_pkg
// Shared types and constants for the SHA-256 APB feeder.
//   phase_t      : top-level sequencing phases of one block hash
//   apb_state_t  : per-transfer APB master states
//   CTRL_INIT / CTRL_NEXT : values written to the peripheral control register
//   STAT_VALID_BIT        : bit of the status register flagging a ready digest
// ---------------------------------------------------------------------------
package sha_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        POLL,
        READ,
        DONE
    } phase_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_SETUP,
        A_ACCESS
    } apb_state_t;

    localparam logic [31:0] CTRL_INIT      = 32'h1;
    localparam logic [31:0] CTRL_NEXT      = 32'h2;
    localparam int          STAT_VALID_BIT = 0;

    localparam int MSG_WORDS = 16;
    localparam int DIG_WORDS = 8;

    // Control word that starts the hash: INIT for the first block of a
    // message, NEXT for every continuation block.
    function automatic logic [31:0] ctrl_word(input logic first);
        return first ? CTRL_INIT : CTRL_NEXT;
    endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// ---------------------------------------------------------------------------
// apb_master_xfer
// Runs single APB transfers on request and owns every APB pin.
// Each transfer is SETUP, ACCESS (held until pready), then one idle cycle
// with psel/penable low and address/data/pwrite back at 0.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   req, wr, addr, wdata: transfer request; sampled only when the master is
//                         idle, so the requester may update them freely
//                         while a transfer is in flight
//   done                : high in the completing ACCESS cycle
//   rdata, err          : read data / slave error, valid with done
//   paddr, pwdata, pwrite, psel, penable : APB outputs (registered)
//   prdata, pready, pslverr              : APB inputs
// ---------------------------------------------------------------------------
module apb_master_xfer
    import sha_feeder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t state;

    // Completion is the ACCESS cycle in which the slave raises pready; the
    // requester reacts on that same edge so the following idle cycle already
    // carries the next request.
    assign done  = (state == A_ACCESS) && pready;
    assign rdata = prdata;
    assign err   = done && pslverr;

    // Transfer timing. Requests are only taken from A_IDLE, which is what
    // forces the single idle cycle between consecutive transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= A_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
        end else begin
            case (state)
                A_IDLE: begin
                    if (req) begin
                        state   <= A_SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        paddr   <= addr;
                        pwdata  <= wdata;
                        pwrite  <= wr;
                    end
                end
                A_SETUP: begin
                    state   <= A_ACCESS;
                    penable <= 1'b1;
                end
                A_ACCESS: begin
                    if (pready) begin
                        state   <= A_IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        paddr   <= '0;
                        pwdata  <= '0;
                        pwrite  <= 1'b0;
                    end
                end
                default: begin
                    state   <= A_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sha_apb_feeder.sv
// ---------------------------------------------------------------------------
// sha_apb_feeder
// APB master sequencer in front of the SHA-256 APB peripheral. Takes one
// 512-bit block, writes its 16 words, starts INIT or NEXT, polls STATUS,
// reads the 8 digest words back and offers the digest downstream.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   blk_valid_i/blk_ready_o  : block handshake (ready only while idle)
//   blk_i, blk_first_i       : block (word 0 in [511:480]), first-of-message
//   PADDR..PENABLE           : APB outputs
//   PRDATA, PREADY, PSLVERR  : APB inputs
//   dig_valid_o/dig_ready_i  : digest handshake
//   dig_o                    : digest (word 0 in [255:224])
//   err_o                    : one-cycle pulse on slave error or poll timeout
// ---------------------------------------------------------------------------
module sha_apb_feeder
    import sha_feeder_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] DATA_BASE = 12'h000,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 12'h040,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 12'h044,
    parameter logic [ADDR_W-1:0] DIG_BASE  = 12'h080,
    parameter int                POLL_MAX  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    input  logic [511:0]      blk_i,
    input  logic              blk_first_i,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              dig_valid_o,
    input  logic              dig_ready_i,
    output logic [255:0]      dig_o,
    output logic              err_o
);

    localparam int POLL_W = $clog2(POLL_MAX + 1);

    phase_t            phase;
    logic [3:0]        idx;
    logic [POLL_W-1:0] poll_cnt;
    logic [POLL_W-1:0] poll_next;
    logic [511:0]      hold;
    logic              first;

    logic              xfer_req;
    logic              xfer_wr;
    logic [ADDR_W-1:0] xfer_addr;
    logic [31:0]       xfer_wdata;
    logic              xfer_done;
    logic [31:0]       xfer_rdata;
    logic              xfer_err;
    logic              poll_timeout;
    logic              abort;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [3:0]        i);
        return base + ADDR_W'({i, 2'b00});
    endfunction

    apb_master_xfer #(
        .ADDR_W (ADDR_W)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .req     (xfer_req),
        .wr      (xfer_wr),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .done    (xfer_done),
        .rdata   (xfer_rdata),
        .err     (xfer_err),
        .paddr   (PADDR),
        .pwdata  (PWDATA),
        .pwrite  (PWRITE),
        .psel    (PSEL),
        .penable (PENABLE),
        .prdata  (PRDATA),
        .pready  (PREADY),
        .pslverr (PSLVERR)
    );

    // The request presented to the APB master is a pure function of the
    // current phase and word index. The holding register is shifted after
    // each LOAD write, so the word to send is always its top 32 bits.
    always_comb begin
        xfer_req   = 1'b0;
        xfer_wr    = 1'b0;
        xfer_addr  = '0;
        xfer_wdata = '0;
        case (phase)
            LOAD: begin
                xfer_req   = 1'b1;
                xfer_wr    = 1'b1;
                xfer_addr  = word_addr(DATA_BASE, idx);
                xfer_wdata = hold[511:480];
            end
            START: begin
                xfer_req   = 1'b1;
                xfer_wr    = 1'b1;
                xfer_addr  = CTRL_ADDR;
                xfer_wdata = ctrl_word(first);
            end
            POLL: begin
                xfer_req  = 1'b1;
                xfer_addr = STAT_ADDR;
            end
            READ: begin
                xfer_req  = 1'b1;
                xfer_addr = word_addr(DIG_BASE, {1'b0, idx[2:0]});
            end
            default: begin
                xfer_req = 1'b0;
            end
        endcase
    end

    // A failing STATUS read that would bring the read count to POLL_MAX is
    // the timeout; it is handled exactly like a slave error.
    assign poll_next    = poll_cnt + 1'b1;
    assign poll_timeout = (phase == POLL) && !xfer_rdata[STAT_VALID_BIT] &&
                          (poll_next == POLL_W'(POLL_MAX));
    assign abort        = xfer_done && (xfer_err || poll_timeout);

    // Phase sequencer. Advances once per completed transfer; an abort drops
    // everything (including the held block) and returns straight to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= IDLE;
            idx         <= '0;
            poll_cnt    <= '0;
            hold        <= '0;
            first       <= 1'b0;
            blk_ready_o <= 1'b0;
            dig_valid_o <= 1'b0;
            dig_o       <= '0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (abort) begin
                phase       <= IDLE;
                idx         <= '0;
                poll_cnt    <= '0;
                hold        <= '0;
                first       <= 1'b0;
                err_o       <= 1'b1;
                blk_ready_o <= 1'b1;
            end else begin
                case (phase)
                    IDLE: begin
                        if (blk_ready_o && blk_valid_i) begin
                            hold        <= blk_i;
                            first       <= blk_first_i;
                            idx         <= '0;
                            blk_ready_o <= 1'b0;
                            phase       <= LOAD;
                        end else begin
                            blk_ready_o <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (xfer_done) begin
                            hold <= {hold[479:0], 32'h0};
                            if (idx == 4'(MSG_WORDS - 1)) begin
                                idx   <= '0;
                                phase <= START;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                    START: begin
                        if (xfer_done) begin
                            poll_cnt <= '0;
                            phase    <= POLL;
                        end
                    end
                    POLL: begin
                        if (xfer_done) begin
                            if (xfer_rdata[STAT_VALID_BIT]) begin
                                idx   <= '0;
                                phase <= READ;
                            end else begin
                                poll_cnt <= poll_next;
                            end
                        end
                    end
                    READ: begin
                        if (xfer_done) begin
                            for (int k = 0; k < DIG_WORDS; k++) begin
                                if (idx[2:0] == 3'(k)) begin
                                    dig_o[255 - 32*k -: 32] <= xfer_rdata;
                                end
                            end
                            if (idx == 4'(DIG_WORDS - 1)) begin
                                idx         <= '0;
                                dig_valid_o <= 1'b1;
                                phase       <= DONE;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                    DONE: begin
                        // Digest stays put until the consumer takes it.
                        if (dig_ready_i) begin
                            dig_valid_o <= 1'b0;
                            blk_ready_o <= 1'b1;
                            phase       <= IDLE;
                        end
                    end
                    default: begin
                        phase <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_apb_feeder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sha_apb_feeder
// Drives blocks into sha_apb_feeder against a model SHA peripheral slave and
// compares the observed APB transfer list, timing and digest with a
// reference model computed from the block, plus a second instance with a
// short poll limit for the timeout case.
// ---------------------------------------------------------------------------
module tb_sha_apb_feeder;

    localparam int ADDR_W = 12;
    localparam int LOGN   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT under main test
    logic              blk_valid_i = 1'b0;
    logic              blk_ready_o;
    logic [511:0]      blk_i = '0;
    logic              blk_first_i = 1'b0;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE, PSEL, PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic              dig_valid_o;
    logic              dig_ready_i = 1'b0;
    logic [255:0]      dig_o;
    logic              err_o;

    // Short-poll-limit instance with a slave whose status never goes ready
    logic              blk_valid2 = 1'b0;
    logic              blk_ready2;
    logic [ADDR_W-1:0] paddr2;
    logic [31:0]       pwdata2;
    logic              pwrite2, psel2, penable2;
    logic              dig_valid2;
    logic [255:0]      dig2;
    logic              err2;

    sha_apb_feeder dut (
        .clk(clk), .rst(rst),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
        .blk_i(blk_i), .blk_first_i(blk_first_i),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .dig_valid_o(dig_valid_o), .dig_ready_i(dig_ready_i), .dig_o(dig_o), .err_o(err_o)
    );

    sha_apb_feeder #(.POLL_MAX(4)) dut_to (
        .clk(clk), .rst(rst),
        .blk_valid_i(blk_valid2), .blk_ready_o(blk_ready2),
        .blk_i(blk_i), .blk_first_i(blk_first_i),
        .PADDR(paddr2), .PWDATA(pwdata2), .PWRITE(pwrite2), .PSEL(psel2), .PENABLE(penable2),
        .PRDATA(32'h0), .PREADY(psel2 && penable2), .PSLVERR(1'b0),
        .dig_valid_o(dig_valid2), .dig_ready_i(1'b1), .dig_o(dig2), .err_o(err2)
    );

    // ---------------- model peripheral ----------------
    int                wait_states = 0;
    int                stat_zeros  = 0;   // -1: status never ready
    bit                err_en      = 1'b0;
    logic [ADDR_W-1:0] err_addr    = '0;
    logic [31:0]       dig_regs [8];
    int                acc_cnt     = 0;
    int                stat_seen   = 0;
    logic [44:0]       log_q   [LOGN];
    int                log_len [LOGN];
    int                log_cnt     = 0;
    int                viol_cnt    = 0;
    int                err_cnt     = 0;
    bit                prev_done   = 1'b0;
    logic [44:0]       setup_cap   = '0;
    int                to_xfers = 0, to_stat = 0, to_err = 0, to_digv = 0;

    assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_states);
    assign PSLVERR = PREADY && err_en && (PADDR == err_addr);

    always_comb begin
        PRDATA = 32'hDEAD_BEEF;
        if (PADDR == 12'h044)
            PRDATA = {31'h52A5_0F0F, !(stat_zeros < 0 || stat_seen < stat_zeros)};
        else if (PADDR[11:5] == 7'h04)
            PRDATA = dig_regs[PADDR[4:2]];
    end

    always @(posedge clk) begin
        prev_done <= PREADY;
        err_cnt   <= err_cnt + int'(err_o);
        if (rst) begin
            acc_cnt <= 0;
        end else begin
            if (PSEL && PENABLE) begin
                if (PREADY) begin
                    acc_cnt <= 0;
                    log_q[log_cnt % LOGN]   <= {PWRITE, PADDR, PWRITE ? PWDATA : 32'h0};
                    log_len[log_cnt % LOGN] <= acc_cnt + 1;
                    log_cnt <= log_cnt + 1;
                    if (!PWRITE && PADDR == 12'h044) stat_seen <= stat_seen + 1;
                    if (PWRITE && PADDR == 12'h040) stat_seen <= 0;
                end else begin
                    acc_cnt <= acc_cnt + 1;
                end
            end
            if (PSEL && !PENABLE) setup_cap <= {PWRITE, PADDR, PWDATA};
            viol_cnt <= viol_cnt + int'(PENABLE && !PSEL) + int'(prev_done && PSEL)
                      + int'(PSEL && PENABLE && ({PWRITE, PADDR, PWDATA} != setup_cap))
                      + int'(!PSEL && ({PWRITE, PADDR, PWDATA} != 45'h0));
        end
        if (psel2 && penable2) begin
            to_xfers <= to_xfers + 1;
            if (!pwrite2 && paddr2 == 12'h044) to_stat <= to_stat + 1;
        end
        to_err  <= to_err + int'(err2);
        to_digv <= to_digv + int'(dig_valid2);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    typedef struct {
        bit          first;
        int          wait_states;
        int          stat_zeros;
        int          stall;
        logic [31:0] exp_ctrl;
        int          exp_stat_reads;
        int          exp_access_len;
    } vec_t;

    logic [44:0] exp_q [$];

    // Reference transfer list: 16 word writes, one control write, the status
    // reads, then the 8 digest reads.
    function automatic void build_model(input logic [511:0] blk, input bit first, input int zeros);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 12'(4*i), blk[511 - 32*i -: 32]});
        exp_q.push_back({1'b1, 12'h040, first ? 32'h1 : 32'h2});
        for (int j = 0; j <= zeros; j++) exp_q.push_back({1'b0, 12'h044, 32'h0});
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, 12'(128 + 4*k), 32'h0});
    endfunction

    task automatic applyStimulus(input logic [511:0] blk, input bit first, output bit ok);
        int cyc;
        @(negedge clk);
        blk_i = blk;
        blk_first_i = first;
        blk_valid_i = 1'b1;
        cyc = 0;
        while (!blk_ready_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        ok = (cyc < 200);
        @(posedge clk);
        #1;
        // keep offering a different block while busy; it must be ignored
        blk_i = {16{$urandom()}};
        blk_first_i = ~first;
    endtask

    task automatic runVector(input string tag, input vec_t v, input logic [511:0] blk,
                             input logic [255:0] digest);
        bit ok;
        int base, errs0, edges, unstable, nstat, badlen, nexp;
        logic [31:0] ctrl_seen;
        wait_states = v.wait_states;
        stat_zeros  = v.stat_zeros;
        err_en      = 1'b0;
        for (int k = 0; k < 8; k++) dig_regs[k] = digest[255 - 32*k -: 32];
        build_model(blk, v.first, v.stat_zeros);
        nexp  = exp_q.size();
        base  = log_cnt;
        errs0 = err_cnt;
        applyStimulus(blk, v.first, ok);
        checkOutput({tag, " accepted"}, 256'(ok), 256'(1));
        checkOutput({tag, " ready drop"}, 256'(blk_ready_o), 256'(0));
        edges = 0;
        while (!dig_valid_o && edges < 3000) begin
            @(posedge clk);
            #1;
            edges++;
        end
        blk_valid_i = 1'b0;
        checkOutput({tag, " latency"}, 256'(edges), 256'((3 + v.wait_states) * nexp));
        checkOutput({tag, " digest"}, dig_o, digest);
        unstable = 0;
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            if (!dig_valid_o || dig_o !== digest || blk_ready_o) unstable++;
        end
        checkOutput({tag, " stall hold"}, 256'(unstable), 256'(0));
        @(negedge clk);
        dig_ready_i = 1'b1;
        @(posedge clk);
        #1;
        dig_ready_i = 1'b0;
        checkOutput({tag, " valid after take"}, 256'(dig_valid_o), 256'(0));
        checkOutput({tag, " ready after take"}, 256'(blk_ready_o), 256'(1));
        checkOutput({tag, " xfer count"}, 256'(log_cnt - base), 256'(nexp));
        nstat = 0;
        badlen = 0;
        ctrl_seen = '0;
        for (int e = 0; e < nexp && e < log_cnt - base; e++) begin
            checkOutput($sformatf("%s xfer %0d", tag, e), 256'(log_q[(base + e) % LOGN]), 256'(exp_q[e]));
            if (log_q[(base + e) % LOGN][43:32] == 12'h044) nstat++;
            if (log_q[(base + e) % LOGN][43:32] == 12'h040) ctrl_seen = log_q[(base + e) % LOGN][31:0];
            if (log_len[(base + e) % LOGN] != v.exp_access_len) badlen++;
        end
        checkOutput({tag, " ctrl data"}, 256'(ctrl_seen), 256'(v.exp_ctrl));
        checkOutput({tag, " stat reads"}, 256'(nstat), 256'(v.exp_stat_reads));
        checkOutput({tag, " access length"}, 256'(badlen), 256'(0));
        checkOutput({tag, " no err"}, 256'(err_cnt - errs0), 256'(0));
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int base, cnt, psel_seen, digv_seen, x0, s0, e0, d0;
        vec_t v;

        vecs[0] = '{1'b1, 0, 0, 0,  32'h1, 1, 1};
        vecs[1] = '{1'b1, 3, 0, 0,  32'h1, 1, 4};
        vecs[2] = '{1'b0, 0, 5, 0,  32'h2, 6, 1};
        vecs[3] = '{1'b0, 1, 2, 20, 32'h2, 3, 2};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset apb", 256'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 256'(0));
        checkOutput("reset ready", 256'(blk_ready_o), 256'(0));
        checkOutput("reset digest", 256'({dig_valid_o, err_o}), 256'(0));
        checkOutput("reset dig_o", dig_o, 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // table vectors: "abc", wait states, slow status, consumer stall
        runVector("abc", vecs[0], ABC_BLOCK, ABC_DIGEST);
        runVector("abc wait3", vecs[1], ABC_BLOCK, ABC_DIGEST);
        for (int i = 2; i < 4; i++) runVector($sformatf("tab%0d", i), vecs[i], rand_block(), rand_digest());

        // randomized blocks
        for (int r = 0; r < 6; r++) begin
            v.first          = 1'($urandom_range(0, 1));
            v.wait_states    = $urandom_range(0, 2);
            v.stat_zeros     = $urandom_range(0, 4);
            v.stall          = $urandom_range(0, 5);
            v.exp_ctrl       = v.first ? 32'h1 : 32'h2;
            v.exp_stat_reads = v.stat_zeros + 1;
            v.exp_access_len = v.wait_states + 1;
            runVector($sformatf("rnd%0d", r), v, rand_block(), rand_digest());
        end

        // slave error on the 5th LOAD write
        wait_states = 0;
        stat_zeros  = 0;
        err_en      = 1'b1;
        err_addr    = 12'h010;
        base = log_cnt;
        digv_seen = 0;
        applyStimulus(rand_block(), 1'b1, ok);
        checkOutput("err accepted", 256'(ok), 256'(1));
        cnt = 0;
        while (!err_o && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (dig_valid_o) digv_seen++;
        end
        blk_valid_i = 1'b0;
        checkOutput("err pulse", 256'(err_o), 256'(1));
        checkOutput("err ready", 256'(blk_ready_o), 256'(1));
        checkOutput("err xfers", 256'(log_cnt - base), 256'(5));
        @(posedge clk);
        #1;
        checkOutput("err single", 256'(err_o), 256'(0));
        psel_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (PSEL) psel_seen++;
            if (dig_valid_o) digv_seen++;
        end
        checkOutput("err quiet bus", 256'(psel_seen), 256'(0));
        checkOutput("err no digest", 256'(digv_seen), 256'(0));
        err_en = 1'b0;

        // reset during a STATUS access, then a continuation block
        wait_states = 3;
        stat_zeros  = -1;
        applyStimulus(rand_block(), 1'b1, ok);
        blk_valid_i = 1'b0;
        cnt = 0;
        while (!(PSEL && PENABLE && PADDR == 12'h044) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("poll access reached", 256'(cnt < 1000), 256'(1));
        rst = 1'b1;
        #1;
        checkOutput("async reset apb", 256'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 256'(0));
        checkOutput("async reset outs", 256'({blk_ready_o, dig_valid_o, err_o}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        v = '{1'b0, 0, 0, 0, 32'h2, 1, 1};
        runVector("after reset", v, rand_block(), rand_digest());

        // poll timeout on the POLL_MAX=4 instance
        x0 = to_xfers;
        s0 = to_stat;
        e0 = to_err;
        d0 = to_digv;
        @(negedge clk);
        blk_valid2 = 1'b1;
        cnt = 0;
        while (!blk_ready2 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        blk_valid2 = 1'b0;
        cnt = 0;
        while (!err2 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("timeout pulse", 256'(err2), 256'(1));
        checkOutput("timeout stat reads", 256'(to_stat - s0), 256'(4));
        checkOutput("timeout xfers", 256'(to_xfers - x0), 256'(21));
        @(posedge clk);
        #1;
        checkOutput("timeout single", 256'(to_err - e0), 256'(1));
        checkOutput("timeout no digest", 256'(to_digv - d0), 256'(0));
        checkOutput("timeout ready", 256'(blk_ready2), 256'(1));

        checkOutput("apb protocol", 256'(viol_cnt), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
